// File: rtl/rgb_table_loader.sv
// Write-side loader for the RGB colour table BRAM: streams entries into port A,
// then reads the table back and compares XOR checksums of written and read data.
module rgb_table_loader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              entry_valid,
  output logic              entry_ready,
  input  logic [DATA_W-1:0] entry_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra counter bit so DEPTH == 2**ADDR_W terminates without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DRAIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [DATA_W-1:0] wsum;
  logic [DATA_W-1:0] rsum;
  logic              rd_vld_p1;
  logic              hs;
  logic [DATA_W-1:0] final_rsum;

  function automatic logic [DATA_W-1:0] xor_acc(input logic [DATA_W-1:0] acc,
                                               input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

  always_comb begin
    entry_ready = (state == WRITE);
    hs          = entry_valid & entry_ready;
    busy        = (state != IDLE);
    bram_en     = 1'b0;
    bram_we     = 1'b0;
    bram_addr   = '0;
    bram_din    = '0;
    if (hs) begin
      bram_en   = 1'b1;
      bram_we   = 1'b1;
      bram_addr = wr_cnt[ADDR_W-1:0];
      bram_din  = entry_data;
    end else if (state == VERIFY) begin
      bram_en   = 1'b1;
      bram_addr = rd_cnt[ADDR_W-1:0];
    end
    final_rsum = xor_acc(rsum, bram_dout);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wsum      <= '0;
      rsum      <= '0;
      rd_vld_p1 <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done      <= 1'b0;
      // Read issued this cycle returns data next cycle.
      rd_vld_p1 <= (state == VERIFY);
      case (state)
        IDLE: begin
          if (start) begin
            state  <= WRITE;
            wr_cnt <= '0;
            rd_cnt <= '0;
            wsum   <= '0;
            rsum   <= '0;
            error  <= 1'b0;
          end
        end
        WRITE: begin
          if (hs) begin
            wsum   <= xor_acc(wsum, entry_data);
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST) state <= VERIFY;
          end
        end
        VERIFY: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_vld_p1) rsum <= final_rsum;
          if (rd_cnt == LAST) state <= DRAIN;
        end
        DRAIN: begin
          rsum  <= final_rsum;
          error <= (final_rsum != wsum);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_table_loader.sv
// Directed bench for rgb_table_loader with a 1-cycle-latency BRAM model.
module tb_rgb_table_loader;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              entry_valid;
  logic              entry_ready;
  logic [DATA_W-1:0] entry_data;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;
  logic              busy;
  logic              done;
  logic              error;

  rgb_table_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .entry_valid(entry_valid), .entry_ready(entry_ready), .entry_data(entry_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] tbl [DEPTH] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                                     24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'h000000};

  // BRAM model; optional corruption of bit 0 at address 5 on read.
  logic [DATA_W-1:0] mem [DEPTH];
  bit corrupt = 1'b0;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else bram_dout <= mem[bram_addr] ^ ((corrupt && bram_addr == 3'd5) ? 24'h1 : 24'h0);
    end
  end

  int cyc = 0;
  int ndone = 0;
  int wlog[$], wtime[$], rlog[$], rtime[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bram_en && bram_we) begin wlog.push_back(int'(bram_addr)); wtime.push_back(cyc); end
    if (bram_en && !bram_we) begin rlog.push_back(int'(bram_addr)); rtime.push_back(cyc); end
    if (done) ndone++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wlog.delete(); wtime.delete(); rlog.delete(); rtime.delete();
  endtask

  // mode 0: valid held high; 1: valid 1,0,0 pattern; 2: stray start pulses mid-load.
  task automatic run_load(input int mode, input bit exp_err);
    int idx, c, lat, d0;
    bit hs;
    d0 = ndone;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("err_clear_on_start", error, 1'b0);
    check("busy_in_write", busy, 1'b1);
    idx = 0; c = 0;
    while (idx < DEPTH && c < 200) begin
      entry_valid = (mode == 1) ? (c % 3 == 0) : 1'b1;
      entry_data  = tbl[idx];
      start       = (mode == 2 && c == 2);
      hs = entry_valid && entry_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      c++;
    end
    entry_valid = 1'b0;
    check("writes_completed", idx, DEPTH);
    check("ready_drop", entry_ready, 1'b0);
    lat = 0;
    while (!done && lat < 50) begin
      start = (mode == 2 && lat == 3);
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check("done_latency", lat, DEPTH + 1);
    check("busy_at_done", busy, 1'b0);
    check("error_at_done", error, exp_err);
    repeat (3) @(posedge clk);
    #1;
    check("single_done", ndone - d0, 1);
    check("idle_after", busy, 1'b0);
  endtask

  task automatic check_logs(input bit contiguous);
    check("wr_count", wlog.size(), DEPTH);
    check("rd_count", rlog.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < wlog.size()) check($sformatf("wr_addr%0d", i), wlog[i], i);
      if (i < rlog.size()) check($sformatf("rd_addr%0d", i), rlog[i], i);
      check($sformatf("mem%0d", i), mem[i], tbl[i]);
    end
    if (contiguous && wtime.size() == DEPTH && rtime.size() == DEPTH) begin
      check("wr_back_to_back", wtime[DEPTH-1] - wtime[0], DEPTH - 1);
      check("rd_after_wr", rtime[0] - wtime[DEPTH-1], 1);
      check("rd_back_to_back", rtime[DEPTH-1] - rtime[0], DEPTH - 1);
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b1; entry_valid = 1'b0; entry_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", entry_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_en", bram_en, 1'b0);
    check("rst_we", bram_we, 1'b0);
    check("rst_addr", bram_addr, 0);
    check("rst_din", bram_din, 0);
    start = 1'b0; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_busy", busy, 1'b0);
    check("idle_no_access", wlog.size() + rlog.size(), 0);

    clear_logs();
    run_load(0, 1'b0);
    check_logs(1'b1);

    clear_logs();
    for (int i = 0; i < DEPTH; i++) mem[i] = 'x;
    run_load(1, 1'b0);
    check_logs(1'b0);

    clear_logs();
    corrupt = 1'b1;
    run_load(0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("error_sticky", error, 1'b1);
    corrupt = 1'b0;
    clear_logs();
    run_load(0, 1'b0);
    check_logs(1'b1);

    // Reset after four writes abandons the load.
    clear_logs();
    d0 = ndone;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    entry_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      entry_data = tbl[i];
      @(posedge clk); #1;
    end
    entry_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("midrst_ready", entry_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_writes", wlog.size(), 4);
    repeat (15) @(posedge clk);
    #1;
    check("midrst_no_done", ndone - d0, 0);
    check("midrst_no_reads", rlog.size(), 0);
    clear_logs();
    run_load(0, 1'b0);
    check_logs(1'b1);

    clear_logs();
    run_load(2, 1'b0);
    check_logs(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/rgb_table_loader.md
Name: rgb_table_loader

Overview:
- Write-side companion to the lights colour lookup: fills the 24-bit RGB colour table BRAM (port A) that the converter reads by {heating,cooling} address.
- Accepts colour entries over a valid/ready stream and writes them to sequential addresses 0..DEPTH-1.
- Then reads the whole table back and compares an XOR checksum of the read data with the checksum of the written data.
- Reports completion and pass/fail to the system controller.

Parameters:
- ADDR_W, 3, BRAM address width.
- DATA_W, 24, colour word width (8b R, 8b G, 8b B).
- DEPTH, 8, number of table entries; must be ≤ 2**ADDR_W and ≥ 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- entry_valid  input  1  entry_data is valid.
- entry_ready  output  1  loader accepts an entry this cycle.
- entry_data  input  DATA_W  colour word to write.
- bram_en  output  1  BRAM port A enable.
- bram_we  output  1  BRAM port A write enable.
- bram_addr  output  ADDR_W  BRAM port A address.
- bram_din  output  DATA_W  BRAM port A write data.
- bram_dout  input  DATA_W  BRAM port A read data; 1-cycle read latency.
- busy  output  1  high in WRITE, VERIFY and DRAIN.
- done  output  1  one-cycle pulse at the end of verify.
- error  output  1  checksum mismatch; valid from the done pulse until the next accepted start.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; wr_cnt=0, rd_cnt=0, wsum=0, rsum=0.
  - error=0, done=0, busy=0, entry_ready=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
  - Reset mid-operation abandons the load immediately. BRAM contents already written are left as-is. No done pulse is produced.
- FSM states: IDLE, WRITE, VERIFY, DRAIN.
- IDLE:
  - start=1 moves to WRITE next cycle.
  - On that transition: clear wr_cnt, rd_cnt, wsum, rsum and error.
  - start while busy is ignored.
- WRITE:
  - entry_ready=1 (combinational from state).
  - Handshake = entry_valid & entry_ready.
  - On a handshake cycle: bram_en=1, bram_we=1, bram_addr=wr_cnt, bram_din=entry_data (all combinational, same cycle).
  - On the handshake edge: wsum ^= entry_data, wr_cnt++.
  - Non-handshake cycles: bram_en=0, bram_we=0.
  - The handshake with wr_cnt=DEPTH-1 transitions to VERIFY; entry_ready=0 from the next cycle.
  - entry_valid may stall indefinitely; there is no timeout.
- VERIFY:
  - bram_en=1, bram_we=0, bram_addr=rd_cnt.
  - rd_cnt++ each cycle.
  - After issuing address DEPTH-1, go to DRAIN.
  - Lasts exactly DEPTH cycles.
- Read data accumulation:
  - bram_dout for the address issued in cycle n is valid in cycle n+1.
  - Accumulate rsum ^= bram_dout in the cycle after each issued read: VERIFY cycles 2..DEPTH plus the DRAIN cycle.
  - A valid-delay flag tracks which cycles hold valid read data.
- DRAIN:
  - bram_en=0.
  - Final accumulate, then evaluate final_rsum = rsum ^ bram_dout.
  - error <= (final_rsum != wsum); done <= 1 for one cycle; state→IDLE.
- Timing:
  - done is asserted in the first IDLE cycle after DRAIN.
  - busy falls in the same cycle done rises.
  - From the last write handshake to done: DEPTH+1 cycles.
- Widths: counters are ADDR_W+1 bits so DEPTH=2**ADDR_W terminates without wrap. bram_addr = counter[ADDR_W-1:0].
- Simultaneous events: start held high across done re-arms in the IDLE cycle after done; error is cleared on that acceptance.
- DEPTH=1: WRITE takes one handshake, VERIFY lasts one cycle, DRAIN captures the single read.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0 and state IDLE; release → no activity until start.
- Nominal load (DEPTH=8), using a behavioural BRAM model with 1-cycle latency:
  - Entries 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFF00, 0x00FFFF, 0xFF00FF, 0xFFFFFF, 0x000000 with valid held high.
  - Expect writes to addr 0..7 in 8 consecutive cycles, then reads 0..7.
  - Expect done 9 cycles after the last write and error=0.
- Backpressure: entry_valid toggling 1,0,0,1,… → bram_we only on valid cycles; addresses remain contiguous 0..7; result identical to nominal.
- Corruption: BRAM model flips bit 0 of addr 5 on read (0xFF00FF→0xFF00FE) → done pulse with error=1. error stays 1 until the next start and clears on acceptance.
- Mid-operation reset:
  - Assert rst_n=0 after 4 writes → IDLE, entry_ready=0, no done.
  - A new start then writes from addr 0 again.
- Ignored start: pulse start during WRITE and during VERIFY → no restart; counters unaffected; a single done pulse.
